// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and LD/SD data access.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data always beats fetch.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_VALID,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_GNT,
  output logic              D_VALID,
  output logic [DATA_W-1:0] D_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_RD,
  output logic              MEM_WR,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY,
  output logic [1:0]        ESTADO_ARB
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
      $error("mem_port_arbiter: MEM_LAT must be 1..15");
    end
  endgenerate

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              owner_q;   // 1 = data path, 0 = fetch
  logic              first_q;   // first ACCESS cycle, carries the grant
  logic [3:0]        lat_cnt;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              is_idle, start, win_d;

  // Encoding 3 is unused and behaves exactly like IDLE.
  assign is_idle = (state_q != S_ACCESS) && (state_q != S_RESP);
  assign start   = is_idle && (IF_REQ || D_REQ);

`ifdef MEM_ARB_RR_EN
  logic last_owner_q;

  always_comb win_d = (IF_REQ && D_REQ) ? !last_owner_q : D_REQ;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)   last_owner_q <= 1'b0;
    else if (start) last_owner_q <= win_d;
  end
`else
  always_comb win_d = D_REQ;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_ACCESS: state_d = (lat_cnt == 4'd0) ? S_RESP : S_ACCESS;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = (IF_REQ || D_REQ) ? S_ACCESS : S_IDLE;
    endcase
  end

  // Request is latched at grant so requesters may change inputs freely afterwards.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_q    <= 1'b0;
      first_q    <= 1'b0;
      lat_cnt    <= 4'd0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (start) begin
      addr_q  <= win_d ? D_ADDR : IF_ADDR;
      wdata_q <= win_d ? D_WDATA : '0;
      we_q    <= win_d && D_WE;
      owner_q <= win_d;
      first_q <= 1'b1;
      lat_cnt <= 4'(MEM_LAT - 1);
    end else begin
      first_q <= 1'b0;
      if (state_q == S_ACCESS) begin
        if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
        else if (!we_q) begin
          if (owner_q) d_rdata_q  <= MEM_RDATA;
          else         if_rdata_q <= MEM_RDATA;
        end
      end
    end
  end

  always_comb begin
    IF_GNT     = 1'b0;
    D_GNT      = 1'b0;
    IF_VALID   = 1'b0;
    D_VALID    = 1'b0;
    MEM_RD     = 1'b0;
    MEM_WR     = 1'b0;
    MEM_ADDR   = '0;
    MEM_WDATA  = '0;
    if (state_q == S_ACCESS) begin
      IF_GNT    = first_q && !owner_q;
      D_GNT     = first_q && owner_q;
      MEM_RD    = !we_q;
      MEM_WR    = we_q;
      MEM_ADDR  = addr_q;
      MEM_WDATA = wdata_q;
    end
    if (state_q == S_RESP) begin
      IF_VALID = !owner_q;
      D_VALID  = owner_q;
    end
  end

  assign IF_RDATA   = if_rdata_q;
  assign D_RDATA    = d_rdata_q;
  assign BUSY       = !is_idle;
  assign ESTADO_ARB = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 main instance plus MEM_LAT=1/15 latency instances.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        IF_REQ, D_REQ, D_WE;
  logic [31:0] IF_ADDR, D_ADDR, D_WDATA;
  logic        IF_GNT, IF_VALID, D_GNT, D_VALID, MEM_RD, MEM_WR, BUSY;
  logic [31:0] IF_RDATA, D_RDATA, MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic [1:0]  ESTADO_ARB;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  // Memory model: one fixed instruction word, every other address reads back ~addr.
  assign MEM_RDATA = (MEM_ADDR == 32'h10) ? 32'h00A00093 : ~MEM_ADDR;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_VALID(IF_VALID), .IF_RDATA(IF_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
    .MEM_RDATA(MEM_RDATA), .BUSY(BUSY), .ESTADO_ARB(ESTADO_ARB)
  );

  // Latency instances: index 0 -> MEM_LAT=1, index 1 -> MEM_LAT=15; data loads only.
  logic        x_d_req   [2];
  logic [31:0] x_d_addr  [2];
  logic        x_if_gnt  [2], x_if_valid [2], x_d_gnt [2], x_d_valid [2];
  logic        x_mem_rd  [2], x_mem_wr [2], x_busy [2];
  logic [31:0] x_if_rdata[2], x_d_rdata [2], x_mem_addr [2], x_mem_wdata [2], x_mem_rdata [2];
  logic [1:0]  x_st      [2];

  for (genvar g = 0; g < 2; g++) begin : g_lat
    assign x_mem_rdata[g] = ~x_mem_addr[g];
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 15)) u_lat (
      .CLK(CLK), .RESET_N(RESET_N),
      .IF_REQ(1'b0), .IF_ADDR(32'h0), .IF_GNT(x_if_gnt[g]), .IF_VALID(x_if_valid[g]),
      .IF_RDATA(x_if_rdata[g]),
      .D_REQ(x_d_req[g]), .D_WE(1'b0), .D_ADDR(x_d_addr[g]), .D_WDATA(32'h0),
      .D_GNT(x_d_gnt[g]), .D_VALID(x_d_valid[g]), .D_RDATA(x_d_rdata[g]),
      .MEM_ADDR(x_mem_addr[g]), .MEM_WDATA(x_mem_wdata[g]), .MEM_RD(x_mem_rd[g]),
      .MEM_WR(x_mem_wr[g]), .MEM_RDATA(x_mem_rdata[g]), .BUSY(x_busy[g]), .ESTADO_ARB(x_st[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Request issued in cycle 0; GNT expected in cycle 1, VALID in cycle lat+1.
  task automatic lat_test(input int k, input int lat, input logic [31:0] a);
    int gcyc = -1;
    int vcyc = -1;
    x_d_addr[k] = a;
    x_d_req[k]  = 1'b1;
    for (int c = 1; c <= 40 && vcyc < 0; c++) begin
      tick;
      if (x_d_gnt[k]) begin
        gcyc        = c;
        x_d_req[k]  = 1'b0;
        x_d_addr[k] = 32'hFFFF_0000;
      end
      if (x_mem_rd[k]) chk("lat_mem_addr", x_mem_addr[k], a);
      if (x_d_valid[k]) vcyc = c;
    end
    x_d_req[k] = 1'b0;
    chk("lat_gnt_cycle",   gcyc, 1);
    chk("lat_valid_cycle", vcyc, lat + 1);
    chk("lat_rdata",       x_d_rdata[k], ~a);
  endtask

  initial begin
    logic seen;
    RESET_N = 1'b0;
    IF_REQ = 1'b0; IF_ADDR = '0; D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0;
    for (int k = 0; k < 2; k++) begin x_d_req[k] = 1'b0; x_d_addr[k] = '0; end
    tick; tick;
    chk("rst_busy",   BUSY, 0);
    chk("rst_state",  ESTADO_ARB, 0);
    chk("rst_if_rd",  IF_RDATA, 0);
    chk("rst_d_rd",   D_RDATA, 0);
    chk("rst_strobe", {MEM_RD, MEM_WR, IF_GNT, D_GNT, IF_VALID, D_VALID}, 0);
    chk("rst_addr",   MEM_ADDR, 0);
    RESET_N = 1'b1;
    tick;

    // Single fetch
    IF_REQ = 1'b1; IF_ADDR = 32'h10;
    chk("f_c0_gnt", IF_GNT, 0);
    tick;
    chk("f_c1_gnt", IF_GNT, 1);
    chk("f_c1_rd",  {MEM_RD, MEM_WR}, 2'b10);
    chk("f_c1_adr", MEM_ADDR, 32'h10);
    chk("f_c1_st",  ESTADO_ARB, 1);
    IF_REQ = 1'b0;
    tick;
    chk("f_c2_gnt", IF_GNT, 0);
    chk("f_c2_rd",  MEM_RD, 1);
    tick;
    chk("f_c3_vld", IF_VALID, 1);
    chk("f_c3_rd",  MEM_RD, 0);
    chk("f_c3_st",  ESTADO_ARB, 2);
    chk("f_c3_dat", IF_RDATA, 32'h00A00093);
    tick;
    chk("f_c4_vld",  IF_VALID, 0);
    chk("f_c4_busy", BUSY, 0);

    // Load
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h20;
    tick;
    chk("ld_c1_gnt", D_GNT, 1);
    D_REQ = 1'b0;
    tick; tick;
    chk("ld_c3_vld", D_VALID, 1);
    chk("ld_c3_dat", D_RDATA, 32'hFFFF_FFDF);
    tick;

    // Store, with inputs changed after grant
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h40; D_WDATA = 32'hDEADBEEF;
    tick;
    chk("st_c1_gnt", D_GNT, 1);
    chk("st_c1_wr",  {MEM_RD, MEM_WR}, 2'b01);
    D_REQ = 1'b0; D_ADDR = 32'h99; D_WDATA = 32'h0;
    chk("st_c1_adr", MEM_ADDR, 32'h40);
    chk("st_c1_wd",  MEM_WDATA, 32'hDEADBEEF);
    tick;
    chk("st_c2_wr",  MEM_WR, 1);
    chk("st_c2_adr", MEM_ADDR, 32'h40);
    chk("st_c2_wd",  MEM_WDATA, 32'hDEADBEEF);
    tick;
    chk("st_c3_vld", D_VALID, 1);
    chk("st_c3_wr",  MEM_WR, 0);
    chk("st_c3_dat", D_RDATA, 32'hFFFF_FFDF);
    tick;
    D_WE = 1'b0;

    // Collision: fixed -> data first; round-robin after a data grant -> fetch first
    IF_REQ = 1'b1; IF_ADDR = 32'h14; D_REQ = 1'b1; D_ADDR = 32'h24;
    tick;
    chk("col_c1_dgnt",  D_GNT, !RR);
    chk("col_c1_ifgnt", IF_GNT, RR);
    if (D_GNT)  D_REQ  = 1'b0;
    if (IF_GNT) IF_REQ = 1'b0;
    tick; tick;
    chk("col_c3_dvld",  D_VALID, !RR);
    chk("col_c3_ifvld", IF_VALID, RR);
    tick;
    chk("col_c4_busy",  BUSY, 0);
    tick;
    chk("col_c5_ifgnt", IF_GNT, !RR);
    chk("col_c5_dgnt",  D_GNT, RR);
    IF_REQ = 1'b0; D_REQ = 1'b0;
    tick; tick;
    chk("col_c7_ifvld", IF_VALID, !RR);
    chk("col_c7_dvld",  D_VALID, RR);
    chk("col_if_dat",   IF_RDATA, 32'hFFFF_FFEB);
    chk("col_d_dat",    D_RDATA, 32'hFFFF_FFDB);
    tick;

    // Reset during the second ACCESS cycle of a store
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h44; D_WDATA = 32'h12345678;
    tick;
    chk("rs_c1_gnt", D_GNT, 1);
    D_REQ = 1'b0; D_WE = 1'b0;
    tick;
    chk("rs_c2_wr", MEM_WR, 1);
    RESET_N = 1'b0;
    #1;
    chk("rs_wr_drop", MEM_WR, 0);
    chk("rs_busy",    BUSY, 0);
    chk("rs_state",   ESTADO_ARB, 0);
    chk("rs_d_dat",   D_RDATA, 0);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      seen = seen | D_VALID;
      if (c == 0) RESET_N = 1'b1;
    end
    chk("rs_no_vld", seen, 0);
    D_REQ = 1'b1; D_ADDR = 32'h28;
    tick;
    chk("rs_new_gnt", D_GNT, 1);
    D_REQ = 1'b0;
    tick; tick;
    chk("rs_new_vld", D_VALID, 1);
    chk("rs_new_dat", D_RDATA, 32'hFFFF_FFD7);
    tick;

    lat_test(0, 1,  32'h0000_0100);
    tick;
    lat_test(1, 15, 32'h0000_0200);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
